pipe_ctrl: RTL

Central sequencing controller for the 5-stage MIPS pipeline. It drives per-register enable and flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, control-transfer flushes and multi-cycle data-memory waits, and it drains the pipe on `halt`. It sits beside the datapath and owns no data, only the freeze/bubble decisions for every stage register.

---
 rtl/pipe_ctrl_if.sv | 47 ++++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Control-side bundle between the datapath and pipe_ctrl: hazard/flow inputs and
// per-stage enable/flush strobes. Counter ports exist only with PIPE_CTRL_PERF_EN.
interface pipe_ctrl_if;
  logic [4:0]  rs_if_id;
  logic [4:0]  rt_if_id;
  logic        uses_rt_if_id;
  logic        MemRead_id_ex;
  logic [4:0]  rt_id_ex;
  logic        branch_taken_ex;
  logic [1:0]  Jump_id;
  logic        halt_id;
  logic        halt_mem_wb;
  logic        mem_req;
  logic        mem_ack;
  logic        pc_en;
  logic        en_if_id;
  logic        en_id_ex;
  logic        en_ex_mem;
  logic        en_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  modport master (
`ifdef PIPE_CTRL_PERF_EN
    input  stall_cycles, flush_count,
`endif
    output rs_if_id, rt_if_id, uses_rt_if_id, MemRead_id_ex, rt_id_ex,
    output branch_taken_ex, Jump_id, halt_id, halt_mem_wb, mem_req, mem_ack,
    input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    input  flush_if_id, flush_id_ex, halted
  );

  modport slave (
`ifdef PIPE_CTRL_PERF_EN
    output stall_cycles, flush_count,
`endif
    input  rs_if_id, rt_if_id, uses_rt_if_id, MemRead_id_ex, rt_id_ex,
    input  branch_taken_ex, Jump_id, halt_id, halt_mem_wb, mem_req, mem_ack,
    output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    output flush_if_id, flush_id_ex, halted
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Freeze/bubble sequencer for the 5-stage MIPS pipeline registers.
// Optional stall/flush performance counters are built with PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   lu;
  logic   mem_stall;
  logic   pc_en_c, en_if_id_c, en_back_c;
  logic   flush_if_id_c, flush_id_ex_c;

  assign lu = bus.MemRead_id_ex && (bus.rt_id_ex != 5'd0) &&
              ((bus.rt_id_ex == bus.rs_if_id) ||
               (bus.uses_rt_if_id && (bus.rt_id_ex == bus.rt_if_id)));

  assign mem_stall = bus.mem_req && !bus.mem_ack;

  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b0;
    en_if_id_c    = 1'b0;
    en_back_c     = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        // Once waiting, only the ack releases the freeze, whatever mem_req does.
        if ((state_q == RUN) ? mem_stall : !bus.mem_ack) begin
          state_d = MEM_WAIT;
        end else begin
          pc_en_c    = 1'b1;
          en_if_id_c = 1'b1;
          en_back_c  = 1'b1;
          state_d    = RUN;
          if (bus.branch_taken_ex) begin
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
          end else begin
            if (lu) begin
              pc_en_c       = 1'b0;
              en_if_id_c    = 1'b0;
              flush_id_ex_c = 1'b1;
            end else if (bus.Jump_id != 2'b00) begin
              flush_if_id_c = 1'b1;
            end
            if (bus.halt_id) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          en_if_id_c    = 1'b1;
          en_back_c     = 1'b1;
          flush_if_id_c = 1'b1;
        end
        if (bus.halt_mem_wb) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        perf_window;

  assign perf_window = (state_q == RUN) || (state_q == MEM_WAIT);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (perf_window && !pc_en_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (perf_window && (flush_if_id_c || flush_id_ex_c) &&
        (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      halted_q       <= 1'b0;
`ifdef PIPE_CTRL_PERF_EN
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
`endif
    end else begin
      state_q        <= state_d;
      halted_q       <= halted_d;
`ifdef PIPE_CTRL_PERF_EN
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
`endif
    end
  end

  // Strobes are gated by rst_n so every register holds while reset is low.
  assign bus.pc_en       = rst_n && pc_en_c;
  assign bus.en_if_id    = rst_n && en_if_id_c;
  assign bus.en_id_ex    = rst_n && en_back_c;
  assign bus.en_ex_mem   = rst_n && en_back_c;
  assign bus.en_mem_wb   = rst_n && en_back_c;
  assign bus.flush_if_id = rst_n && flush_if_id_c;
  assign bus.flush_id_ex = rst_n && flush_id_ex_c;
  assign bus.halted      = halted_q;

endmodule
